ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, fully synchronous to clk50. It oversamples kclk/kin, glitch-filters kclk and frames 11-bit packets. It checks start, odd-parity and stop bits, recovers from stalled frames with a watchdog, and buffers good scan codes in a FIFO with a valid/ready interface. It sits between the PS/2 connector pins and the game input decoder, replacing the kclk-clocked single-register receiver.

---
 rtl/ps2_rx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver synchronous to clk50.
// The PS/2 pins are synchronised and kclk is glitch-filtered. Each falling
// edge of the filtered kclk advances an 11-bit frame decoder, which checks
// the start, odd-parity and stop bits. A watchdog abandons stalled frames,
// and good scan codes are buffered in a show-ahead FIFO with valid/ready.
// Optional feature macro: PS2_PREFIX_DECODE_EN. When it is defined, E0/F0
// prefix bytes become ext/brk flags on the next code instead of FIFO entries.
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic                       kclk,
  input  logic                       kin,
  output logic [7:0]                 code_out,
  output logic [1:0]                 code_flags,
  output logic                       code_valid,
  input  logic                       code_ready,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $clog2(FILTER_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] r_kclkSync;
  logic [SYNC_STAGES-1:0] r_kinSync;
  logic                   w_kclkS;
  logic                   w_kinS;

  logic                   r_kclkFilt;
  logic                   r_kclkFiltPrev;
  logic [FW-1:0]          r_filtCnt;
  logic                   w_fall;

  logic [1:0]             r_state;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_wdCnt;
  logic                   r_good;
  logic [7:0]             r_goodByte;
  logic                   r_frameErr;

  logic                   w_push;
  logic [EW-1:0]          w_pushData;

  logic [EW-1:0]          r_mem [DEPTH];
  logic [PW-1:0]          r_wrPtr;
  logic [PW-1:0]          r_rdPtr;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_write;
  logic [EW-1:0]          w_head;

  assign w_kclkS = r_kclkSync[SYNC_STAGES-1];
  assign w_kinS  = r_kinSync[SYNC_STAGES-1];

  // Bring both asynchronous PS/2 pins into the clk50 domain; idle lines are high
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_kclkSync <= '1;
      r_kinSync  <= '1;
    end else begin
      r_kclkSync <= {r_kclkSync[SYNC_STAGES-2:0], kclk};
      r_kinSync  <= {r_kinSync[SYNC_STAGES-2:0], kin};
    end
  end

  // Only let the filtered clock follow kclk after FILTER_LEN matching samples
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_kclkFilt     <= 1'b1;
      r_kclkFiltPrev <= 1'b1;
      r_filtCnt      <= '0;
    end else begin
      r_kclkFiltPrev <= r_kclkFilt;
      if (w_kclkS == r_kclkFilt) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FW'(FILTER_LEN-1)) begin
        r_kclkFilt <= w_kclkS;
        r_filtCnt  <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  assign w_fall = r_kclkFiltPrev & ~r_kclkFilt;

  // Frame decoder stepped by filtered falls, with a watchdog for stalled frames
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_wdCnt    <= '0;
      r_good     <= 1'b0;
      r_goodByte <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_good     <= 1'b0;
      r_frameErr <= 1'b0;
      if (r_state == S_IDLE || w_fall) begin
        r_wdCnt <= '0;
      end else begin
        r_wdCnt <= r_wdCnt + 1'b1;
      end
      if (r_state != S_IDLE && !w_fall && r_wdCnt == TW'(TIMEOUT_CYC-1)) begin
        r_state    <= S_IDLE;
        r_bitCnt   <= '0;
        r_shift    <= '0;
        r_frameErr <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_kinS) begin
              r_state  <= S_DATA;
              r_bitCnt <= '0;
            end else begin
              r_frameErr <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift  <= {w_kinS, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= w_kinS;
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (w_kinS && (^{r_shift, r_parity})) begin
              r_good     <= 1'b1;
              r_goodByte <= r_shift;
            end else begin
              r_frameErr <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign frame_err = r_frameErr;

`ifdef PS2_PREFIX_DECODE_EN
  logic r_ext;
  logic r_brk;
  logic w_isPrefix;

  assign w_isPrefix = (r_goodByte == 8'hE0) || (r_goodByte == 8'hF0);
  assign w_push     = r_good & ~w_isPrefix;
  assign w_pushData = {r_ext, r_brk, r_goodByte};

  // Collect E0/F0 prefixes as pending flags; any rejected frame forgets them
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_frameErr) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_good) begin
      if (r_goodByte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_goodByte == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign code_flags = code_valid ? w_head[9:8] : 2'b00;
`else
  assign w_push     = r_good;
  assign w_pushData = r_goodByte;
  assign code_flags = 2'b00;
`endif

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = code_valid & code_ready;
  assign w_write = w_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rdPtr];

  // FIFO storage; entries are only ever read while the FIFO reports valid
  always_ff @(posedge clk50) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= w_pushData;
    end
  end

  // Pointer and occupancy bookkeeping plus the sticky overflow flag
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_write && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign code_valid = (r_count != '0);
  assign code_out   = code_valid ? w_head[7:0] : 8'h00;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo. A PS/2 device is emulated
// with a fast kclk and a short watchdog so the whole run stays compact.
// Build with PS2_PREFIX_DECODE_EN defined to exercise the prefix decoding.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 40;
  localparam int GAP     = 100;

  logic       clk50;
  logic       reset;
  logic       kclk;
  logic       kin;
  logic [7:0] codeOut;
  logic [1:0] codeFlags;
  logic       codeValid;
  logic       codeReady;
  logic       frameErr;
  logic       overflow;
  logic       ovfClr;
  logic [3:0] fifoCount;

  int checks;
  int errors;
  int errPulses;
  int errBase;

  ps2_rx_fifo #(
    .DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .FILTER_LEN(8),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .kclk(kclk),
    .kin(kin),
    .code_out(codeOut),
    .code_flags(codeFlags),
    .code_valid(codeValid),
    .code_ready(codeReady),
    .frame_err(frameErr),
    .overflow(overflow),
    .ovf_clr(ovfClr),
    .fifo_count(fifoCount)
  );

  // 50 MHz system clock
  initial begin
    clk50 = 1'b0;
    forever #10 clk50 = ~clk50;
  end

  // Count every cycle in which frame_err is high
  always @(posedge clk50) begin
    if (frameErr === 1'b1) begin
      errPulses <= errPulses + 1;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic b, input logic glitch);
    kin = b;
    if (glitch) begin
      waitCycles(10);
      kclk = 1'b0;
      waitCycles(3);
      kclk = 1'b1;
      waitCycles(HALF - 13);
    end else begin
      waitCycles(HALF);
    end
    kclk = 1'b0;
    waitCycles(HALF);
    kclk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par,
                               input logic stopBit, input int glitchBit);
    logic [10:0] frame;
    frame = {stopBit, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      sendBit(frame[i], i == glitchBit);
    end
    kin = 1'b1;
    waitCycles(GAP);
  endtask

  task automatic sendGood(input logic [7:0] data);
    applyStimulus(data, ~^data, 1'b1, -1);
  endtask

  task automatic popOne();
    codeReady = 1'b1;
    waitCycles(1);
    codeReady = 1'b0;
    waitCycles(1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    errPulses = 0;
    reset     = 1'b0;
    kclk      = 1'b1;
    kin       = 1'b1;
    codeReady = 1'b0;
    ovfClr    = 1'b0;
    waitCycles(3);
    checkOutput("rst_code", codeOut, 8'h00);
    checkOutput("rst_flags", codeFlags, 2'b00);
    checkOutput("rst_valid", codeValid, 1'b0);
    checkOutput("rst_ferr", frameErr, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_count", fifoCount, 4'd0);
    reset = 1'b1;
    waitCycles(20);

    $display("[TB] good frame 0x1C");
    errBase = errPulses;
    sendGood(8'h1C);
    checkOutput("f1c_code", codeOut, 8'h1C);
    checkOutput("f1c_flags", codeFlags, 2'b00);
    checkOutput("f1c_valid", codeValid, 1'b1);
    checkOutput("f1c_count", fifoCount, 4'd1);
    checkOutput("f1c_noerr", errPulses - errBase, 0);
    popOne();
    checkOutput("f1c_popped", codeValid, 1'b0);

    $display("[TB] bad parity and bad stop");
    errBase = errPulses;
    applyStimulus(8'h1C, 1'b1, 1'b1, -1);
    checkOutput("par_err", errPulses - errBase, 1);
    checkOutput("par_count", fifoCount, 4'd0);
    errBase = errPulses;
    applyStimulus(8'h1C, 1'b0, 1'b0, -1);
    checkOutput("stop_err", errPulses - errBase, 1);
    checkOutput("stop_count", fifoCount, 4'd0);

    $display("[TB] stalled frame then 0x29");
    errBase = errPulses;
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    kin = 1'b1;
    waitCycles(TIMEOUT + 200);
    checkOutput("wd_err", errPulses - errBase, 1);
    checkOutput("wd_count", fifoCount, 4'd0);
    errBase = errPulses;
    sendGood(8'h29);
    checkOutput("wd_next_code", codeOut, 8'h29);
    checkOutput("wd_next_noerr", errPulses - errBase, 0);
    popOne();

    $display("[TB] overflow");
    for (int i = 1; i <= DEPTH + 1; i++) begin
      sendGood(8'(i));
    end
    checkOutput("ovf_count", fifoCount, 4'd8);
    checkOutput("ovf_flag", overflow, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput("drain_code", codeOut, 32'(i));
      popOne();
    end
    checkOutput("drain_empty", codeValid, 1'b0);
    checkOutput("ovf_sticky", overflow, 1'b1);
    ovfClr = 1'b1;
    waitCycles(1);
    ovfClr = 1'b0;
    waitCycles(1);
    checkOutput("ovf_clr", overflow, 1'b0);

    $display("[TB] kclk glitch inside 0x5A");
    errBase = errPulses;
    applyStimulus(8'h5A, ~^8'h5A, 1'b1, 5);
    checkOutput("glitch_code", codeOut, 8'h5A);
    checkOutput("glitch_count", fifoCount, 4'd1);
    checkOutput("glitch_noerr", errPulses - errBase, 0);
    popOne();

`ifdef PS2_PREFIX_DECODE_EN
    $display("[TB] prefix decode E0 F0 75 then 1C");
    sendGood(8'hE0);
    sendGood(8'hF0);
    sendGood(8'h75);
    checkOutput("pfx_count", fifoCount, 4'd1);
    checkOutput("pfx_code", codeOut, 8'h75);
    checkOutput("pfx_flags", codeFlags, 2'b11);
    popOne();
    sendGood(8'h1C);
    checkOutput("pfx_plain_code", codeOut, 8'h1C);
    checkOutput("pfx_plain_flags", codeFlags, 2'b00);
    popOne();
`else
    $display("[TB] prefix bytes stored raw");
    sendGood(8'hE0);
    checkOutput("raw_count", fifoCount, 4'd1);
    checkOutput("raw_code", codeOut, 8'hE0);
    checkOutput("raw_flags", codeFlags, 2'b00);
    popOne();
`endif

    $display("[TB] reset mid-frame");
    sendGood(8'h1C);
    checkOutput("mid_pre_count", fifoCount, 4'd1);
    errBase = errPulses;
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("mid_count", fifoCount, 4'd0);
    checkOutput("mid_valid", codeValid, 1'b0);
    reset = 1'b1;
    waitCycles(TIMEOUT + 50);
    checkOutput("mid_noerr", errPulses - errBase, 0);
    sendGood(8'h33);
    checkOutput("mid_after_code", codeOut, 8'h33);
    checkOutput("mid_after_count", fifoCount, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
